// File: rtl/memory_access.sv
// rtl/memory_access.sv - MIPS MEM stage: branch resolve, byte/half/word data memory, MEM/WB register
module memory_access #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      inWB,
  input  logic [2:0]      inMEM,
  input  logic [2:0]      inMemSize,
  input  logic [31:0]     inALUResult,
  input  logic            inALUZero,
  input  logic [31:0]     inRegB,
  input  logic [31:0]     inPCJump,
  input  logic [4:0]      inRegF_wreg,
  input  logic [AW-1:0]   dbg_addr,
  output logic [1:0]      outWB,
  output logic [31:0]     outReadData,
  output logic [31:0]     outALUResult,
  output logic [4:0]      outRegF_wreg,
  output logic            outPCSrc,
  output logic [31:0]     outPCJump,
  output logic [31:0]     MEM_AluResult,
  output logic [4:0]      MEM_rd,
  output logic            MEM_regF_wr,
  output logic            outMisaligned,
  output logic [31:0]     dbg_data
);

  logic          branch, mem_read, mem_write;
  logic          is_unsigned;
  logic [1:0]    size;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          misaligned;
  logic          do_store;
  logic          do_load;
  logic [31:0]   word_rd;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic [31:0]   store_word;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic [31:0]   mem_w [DEPTH];

  logic [1:0]    wb_q, wb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   alu_q, alu_d;
  logic [4:0]    wreg_q, wreg_d;
  logic          mis_q, mis_d;

  // Address bits above the memory window are deliberately dropped so accesses wrap.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^inALUResult[31:AW+2];

  assign {branch, mem_read, mem_write} = inMEM;
  assign is_unsigned = inMemSize[2];
  assign size        = inMemSize[1:0];
  assign idx         = inALUResult[AW+1:2];
  assign lane        = inALUResult[1:0];
  assign word_rd     = mem_w[idx];

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      default: misaligned = (lane != 2'b00);
    endcase
  end

  assign do_store = mem_write & ~misaligned;
  assign do_load  = mem_read & ~mem_write & ~misaligned;

  // Replicate the store data across lanes, then let the mask pick which lanes land.
  always_comb begin
    wmask = 4'b0000;
    wdata = inRegB;
    case (size)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wdata = {4{inRegB[7:0]}};
      end
      2'b01: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{inRegB[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = inRegB;
      end
    endcase
  end

  always_comb begin
    store_word = word_rd;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) store_word[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  assign shifted = word_rd >> {lane, 3'b000};

  always_comb begin
    load_data = 32'h0;
    if (do_load) begin
      case (size)
        2'b00: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        2'b01: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        default: load_data = word_rd;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] word_q;
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        word_q <= 32'h0;
      end else if (do_store && (idx == AW'(g))) begin
        word_q <= store_word;
      end
    end
    assign mem_w[g] = word_q;
  end

  always_comb begin
    wb_d    = inWB;
    rdata_d = load_data;
    alu_d   = inALUResult;
    wreg_d  = inRegF_wreg;
    mis_d   = mis_q | ((mem_read | mem_write) & misaligned);
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wb_q    <= 2'b00;
      rdata_q <= 32'h0;
      alu_q   <= 32'h0;
      wreg_q  <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      mis_q   <= mis_d;
    end
  end

  assign outWB         = wb_q;
  assign outReadData   = rdata_q;
  assign outALUResult  = alu_q;
  assign outRegF_wreg  = wreg_q;
  assign outMisaligned = mis_q;

  assign outPCSrc      = branch & inALUZero & rst;
  assign outPCJump     = inPCJump;
  assign MEM_AluResult = inALUResult;
  assign MEM_rd        = inRegF_wreg;
  assign MEM_regF_wr   = inWB[1];
  assign dbg_data      = mem_w[dbg_addr];

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed table plus randomized byte-array model check of memory_access
module tb_memory_access;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst;
  logic [1:0]    inWB;
  logic [2:0]    inMEM;
  logic [2:0]    inMemSize;
  logic [31:0]   inALUResult;
  logic          inALUZero;
  logic [31:0]   inRegB;
  logic [31:0]   inPCJump;
  logic [4:0]    inRegF_wreg;
  logic [AW-1:0] dbg_addr;
  logic [1:0]    outWB;
  logic [31:0]   outReadData;
  logic [31:0]   outALUResult;
  logic [4:0]    outRegF_wreg;
  logic          outPCSrc;
  logic [31:0]   outPCJump;
  logic [31:0]   MEM_AluResult;
  logic [4:0]    MEM_rd;
  logic          MEM_regF_wr;
  logic          outMisaligned;
  logic [31:0]   dbg_data;

  memory_access #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .inWB(inWB), .inMEM(inMEM), .inMemSize(inMemSize),
    .inALUResult(inALUResult), .inALUZero(inALUZero), .inRegB(inRegB),
    .inPCJump(inPCJump), .inRegF_wreg(inRegF_wreg), .dbg_addr(dbg_addr),
    .outWB(outWB), .outReadData(outReadData), .outALUResult(outALUResult),
    .outRegF_wreg(outRegF_wreg), .outPCSrc(outPCSrc), .outPCJump(outPCJump),
    .MEM_AluResult(MEM_AluResult), .MEM_rd(MEM_rd), .MEM_regF_wr(MEM_regF_wr),
    .outMisaligned(outMisaligned), .dbg_data(dbg_data)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: flat little-endian byte array plus a sticky flag.
  logic [7:0] mem_b [4*DEPTH];
  bit         m_mis;

  task automatic model_reset();
    for (int i = 0; i < 4*DEPTH; i++) mem_b[i] = 8'h00;
    m_mis = 0;
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {mem_b[4*i+3], mem_b[4*i+2], mem_b[4*i+1], mem_b[4*i]};
  endfunction

  task automatic model_op(input bit wr, input bit rd, input logic [2:0] msz,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdv);
    int a;
    int n;
    bit mis;
    logic [31:0] v;
    a = int'(addr % (4*DEPTH));
    n = (msz[1:0] == 2'b00) ? 1 : (msz[1:0] == 2'b01) ? 2 : 4;
    mis = (a % n) != 0;
    rdv = 32'h0;
    if ((wr || rd) && mis) m_mis = 1;
    if (wr) begin
      if (!mis) for (int k = 0; k < n; k++) mem_b[a+k] = data[8*k +: 8];
    end else if (rd && !mis) begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem_b[a+k];
      if (!msz[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!msz[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
      rdv = v;
    end
  endtask

  task automatic apply(input bit wr, input bit rd, input logic [2:0] msz,
                       input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    inMEM       = {1'b0, rd, wr};
    inMemSize   = msz;
    inALUResult = addr;
    inRegB      = data;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    bit          wr;
    bit          rd;
    logic [2:0]  msz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] exp_rd;
    logic        br, z, wr, rd;
    logic [2:0]  msz;
    logic [31:0] addr, data, pcj;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic [AW-1:0] da;
    int nz;

    vecs.push_back('{"sw_10",     1, 0, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{"lw_10",     0, 1, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"sw0_20",    1, 0, 3'b010, 32'h20,  32'h0,        32'h0,        0});
    vecs.push_back('{"sb_21",     1, 0, 3'b000, 32'h21,  32'h80,       32'h0,        0});
    vecs.push_back('{"lb_21",     0, 1, 3'b000, 32'h21,  32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{"lbu_21",    0, 1, 3'b100, 32'h21,  32'h0,        32'h00000080, 0});
    vecs.push_back('{"lw_20",     0, 1, 3'b010, 32'h20,  32'h0,        32'h00008000, 0});
    vecs.push_back('{"lh_20",     0, 1, 3'b001, 32'h20,  32'h0,        32'hFFFF8000, 0});
    vecs.push_back('{"lhu_20",    0, 1, 3'b101, 32'h20,  32'h0,        32'h00008000, 0});
    vecs.push_back('{"rdwr_10",   1, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{"sh_03_mis", 1, 0, 3'b001, 32'h03,  32'h1234,     32'h0,        1});
    vecs.push_back('{"lw_00",     0, 1, 3'b010, 32'h00,  32'h0,        32'h0,        1});
    vecs.push_back('{"sw_wrap",   1, 0, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0,        1});
    vecs.push_back('{"lw_wrap",   0, 1, 3'b010, 32'h08,  32'h0,        32'hCAFEF00D, 1});

    rst = 1'b0;
    inWB = 2'b00; inMEM = 3'b000; inMemSize = 3'b000; inALUResult = 32'h0;
    inALUZero = 1'b0; inRegB = 32'h0; inPCJump = 32'h0; inRegF_wreg = 5'd0; dbg_addr = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_readdata", outReadData, 32'h0);
    chk("rst_mis", {31'h0, outMisaligned}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].wr, vecs[i].rd, vecs[i].msz, vecs[i].addr, vecs[i].data);
      chk({vecs[i].name, "_rd"},  outReadData, vecs[i].exp_rd);
      chk({vecs[i].name, "_mis"}, {31'h0, outMisaligned}, {31'h0, vecs[i].exp_mis});
      if (vecs[i].name == "lw_10") begin
        dbg_addr = 6'd4; #1;
        chk("dbg_idx4", dbg_data, 32'hDEADBEEF);
      end
      if (vecs[i].name == "sh_03_mis") begin
        dbg_addr = 6'd0; #1;
        chk("sh_mis_unchanged", dbg_data, 32'h0);
      end
      if (vecs[i].name == "sw_wrap") begin
        dbg_addr = 6'd2; #1;
        chk("dbg_wrap_idx2", dbg_data, 32'hCAFEF00D);
      end
    end

    // Branch and forwarding are combinational: check within the same cycle.
    @(posedge clk); #1;
    inMEM = 3'b100; inALUZero = 1'b1; inPCJump = 32'h40;
    inRegF_wreg = 5'd17; inWB = 2'b10; inALUResult = 32'h1234_5678; #1;
    chk("br_taken", {31'h0, outPCSrc}, 32'h1);
    chk("br_target", outPCJump, 32'h40);
    chk("fwd_rd", {27'h0, MEM_rd}, 32'd17);
    chk("fwd_wr", {31'h0, MEM_regF_wr}, 32'h1);
    chk("fwd_alu", MEM_AluResult, 32'h1234_5678);
    inALUZero = 1'b0; #1;
    chk("br_not_taken", {31'h0, outPCSrc}, 32'h0);

    // Mid-stream async reset with a pending store and a taken branch.
    @(posedge clk); #2;
    inMEM = 3'b101; inALUZero = 1'b1; inMemSize = 3'b010; inALUResult = 32'h10; inRegB = 32'h55;
    rst = 1'b0; #1;
    chk("rst_pcsrc", {31'h0, outPCSrc}, 32'h0);
    chk("rst_wb", {30'h0, outWB}, 32'h0);
    chk("rst_alu", outALUResult, 32'h0);
    chk("rst_wreg", {27'h0, outRegF_wreg}, 32'h0);
    chk("rst_mis_mid", {31'h0, outMisaligned}, 32'h0);
    @(negedge clk); #1;
    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i); #1;
      if (dbg_data != 32'h0) nz++;
    end
    chk("rst_mem_clear", nz, 32'h0);
    model_reset();

    @(posedge clk); #1 rst = 1'b1;
    inMEM = 3'b001; inALUZero = 1'b0; inMemSize = 3'b010; inALUResult = 32'h30;
    inRegB = 32'h11223344; inWB = 2'b11; inRegF_wreg = 5'd9; dbg_addr = 6'd12;
    model_op(1, 0, 3'b010, 32'h30, 32'h11223344, exp_rd);
    @(negedge clk); #1;
    chk("release_dbg", dbg_data, 32'h11223344);
    chk("release_alu", outALUResult, 32'h30);
    chk("release_wreg", {27'h0, outRegF_wreg}, 32'd9);

    for (int it = 0; it < 400; it++) begin
      wr   = 1'($urandom);
      rd   = 1'($urandom);
      br   = 1'($urandom);
      z    = 1'($urandom);
      msz  = 3'($urandom);
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (msz[1:0] == 2'b01) addr[0] = 1'b0;
        else if (msz[1] == 1'b1) addr[1:0] = 2'b00;
      end
      data = $urandom;
      pcj  = $urandom;
      wreg = 5'($urandom);
      wb   = 2'($urandom);
      da   = AW'($urandom);
      @(posedge clk); #1;
      inMEM = {br, rd, wr}; inMemSize = msz; inALUResult = addr; inRegB = data;
      inALUZero = z; inPCJump = pcj; inRegF_wreg = wreg; inWB = wb; dbg_addr = da;
      #1;
      chk("r_pcsrc", {31'h0, outPCSrc}, {31'h0, br & z});
      chk("r_pcjump", outPCJump, pcj);
      chk("r_fwd_rd", {27'h0, MEM_rd}, {27'h0, wreg});
      chk("r_fwd_wr", {31'h0, MEM_regF_wr}, {31'h0, wb[1]});
      chk("r_fwd_alu", MEM_AluResult, addr);
      model_op(wr, rd, msz, addr, data, exp_rd);
      @(negedge clk); #1;
      chk("r_readdata", outReadData, exp_rd);
      chk("r_wb", {30'h0, outWB}, {30'h0, wb});
      chk("r_alu", outALUResult, addr);
      chk("r_wreg", {27'h0, outRegF_wreg}, {27'h0, wreg});
      chk("r_mis", {31'h0, outMisaligned}, {31'h0, m_mis});
      chk("r_dbg", dbg_data, model_word(int'(da)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
